// File: rtl/fresh_pkg.sv
// Shared definitions for the fresh-range stream parser.
//   - ASCII constants used by the line parser
//   - parser section state enum
//   - default bound/ID width
package fresh_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 17;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_DASH = 8'h2d;
  localparam logic [7:0] CH_LF   = 8'h0a;
  localparam logic [7:0] CH_CR   = 8'h0d;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_HIGH = 2'd1,
    S_ID   = 2'd2
  } state_e;

endpackage

// File: rtl/dec_accum.sv
// Decimal multiply-accumulate for one numeric field.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_clr         clear accumulator and digit flag (priority over i_en)
//   i_en          accumulate i_digit (acc = acc*10 + digit)
//   i_digit       BCD digit 0..9
//   o_value       current field value (low ADDR_W bits)
//   o_has_digit   at least one digit accumulated since last clear
//   o_ovf         accumulating i_digit now would exceed 2**ADDR_W-1
module dec_accum
  import fresh_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [3:0]        i_digit,
  output logic [ADDR_W-1:0] o_value,
  output logic              o_has_digit,
  output logic              o_ovf
);

  localparam int unsigned AccW = ADDR_W + 4;
  localparam logic [AccW-1:0] MaxVal = {4'b0000, {ADDR_W{1'b1}}};

  logic [AccW-1:0] r_acc;
  logic            r_has;
  logic [AccW-1:0] w_next;

  // r_acc never exceeds MaxVal (the parent clears on overflow), so acc*10+9
  // always fits in AccW bits.
  assign w_next      = (r_acc * AccW'(10)) + AccW'(i_digit);
  assign o_ovf       = (w_next > MaxVal);
  assign o_value     = r_acc[ADDR_W-1:0];
  assign o_has_digit = r_has;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_has <= 1'b0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_has <= 1'b0;
    end else if (i_en) begin
      r_acc <= w_next;
      r_has <= 1'b1;
    end
  end

endmodule

// File: rtl/range_stream_parser.sv
// Write-side producer for the fresh-range FIFO. Parses "low-high\n" lines, a
// blank line, then "id\n" lines; posts ranges to the FIFO write port and IDs
// on a valid/ready stream.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_data/in_valid/in_ready        ASCII byte input stream
//   fifo_ready                       FIFO can take a write this cycle
//   wr_en, range_low/high/fresh      FIFO write port (range held while pending)
//   id_valid/id_ready/id_addr        parsed ID output stream
//   ranges_done, err_format, err_overflow   sticky status
//   range_count, id_count            saturating transfer counters
// Build option: RANGE_ORDER_FIX_EN swaps low>high ranges instead of dropping
// them with err_format.
module range_stream_parser
  import fresh_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              fifo_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] range_low,
  output logic [ADDR_W-1:0] range_high,
  output logic              range_fresh,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_addr,
  output logic              ranges_done,
  output logic              err_format,
  output logic              err_overflow,
  output logic [CNT_W-1:0]  range_count,
  output logic [CNT_W-1:0]  id_count
);

  state_e            r_state, w_state_d;
  logic              r_bad, w_bad_d;
  logic [ADDR_W-1:0] r_low, w_low_d;
  logic              r_range_pend, w_range_pend_d;
  logic [ADDR_W-1:0] r_rng_low, w_rng_low_d;
  logic [ADDR_W-1:0] r_rng_high, w_rng_high_d;
  logic              r_id_valid, w_id_valid_d;
  logic [ADDR_W-1:0] r_id, w_id_d;
  logic              r_done, w_done_d;
  logic              r_err_fmt, w_err_fmt_d;
  logic              r_err_ovf, w_err_ovf_d;
  logic [CNT_W-1:0]  r_range_count;
  logic [CNT_W-1:0]  r_id_count;

  logic              w_fire;
  logic              w_is_digit;
  logic              w_id_hs;
  logic              w_acc_clr;
  logic              w_acc_en;
  logic [ADDR_W-1:0] w_value;
  logic              w_has_digit;
  logic              w_acc_ovf;

  assign wr_en       = r_range_pend && fifo_ready;
  assign w_id_hs     = r_id_valid && id_ready;
  assign in_ready    = !(r_range_pend && !fifo_ready) && !(r_id_valid && !id_ready);
  assign w_fire      = in_valid && in_ready;
  assign w_is_digit  = (in_data >= CH_0) && (in_data <= CH_9);

  assign range_low    = r_rng_low;
  assign range_high   = r_rng_high;
  assign range_fresh  = r_range_pend;
  assign id_valid     = r_id_valid;
  assign id_addr      = r_id;
  assign ranges_done  = r_done;
  assign err_format   = r_err_fmt;
  assign err_overflow = r_err_ovf;
  assign range_count  = r_range_count;
  assign id_count     = r_id_count;

  dec_accum #(
    .ADDR_W (ADDR_W)
  ) u_dec_accum (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_acc_clr),
    .i_en        (w_acc_en),
    .i_digit     (in_data[3:0]),
    .o_value     (w_value),
    .o_has_digit (w_has_digit),
    .o_ovf       (w_acc_ovf)
  );

  always_comb begin
    w_state_d      = r_state;
    w_bad_d        = r_bad;
    w_low_d        = r_low;
    w_range_pend_d = r_range_pend && !wr_en;
    w_rng_low_d    = r_rng_low;
    w_rng_high_d   = r_rng_high;
    w_id_valid_d   = r_id_valid && !id_ready;
    w_id_d         = r_id;
    w_done_d       = r_done;
    w_err_fmt_d    = r_err_fmt;
    w_err_ovf_d    = r_err_ovf;
    w_acc_clr      = 1'b0;
    w_acc_en       = 1'b0;

    if (w_fire && (in_data != CH_CR)) begin
      if (r_bad) begin
        // Discard the rest of a bad line; its '\n' closes it without posting.
        if (in_data == CH_LF) begin
          w_bad_d   = 1'b0;
          w_acc_clr = 1'b1;
          if (r_state == S_HIGH) w_state_d = S_LOW;
        end
      end else if (w_is_digit) begin
        w_acc_en = 1'b1;
        if (w_acc_ovf) begin
          w_err_ovf_d = 1'b1;
          w_bad_d     = 1'b1;
          w_acc_clr   = 1'b1;
        end
      end else if (in_data == CH_DASH) begin
        w_acc_clr = 1'b1;
        if ((r_state == S_LOW) && w_has_digit) begin
          w_low_d   = w_value;
          w_state_d = S_HIGH;
        end else begin
          w_err_fmt_d = 1'b1;
          w_bad_d     = 1'b1;
        end
      end else if (in_data == CH_LF) begin
        w_acc_clr = 1'b1;
        unique case (r_state)
          S_LOW: begin
            if (!w_has_digit) begin
              w_done_d  = 1'b1;
              w_state_d = S_ID;
            end else begin
              w_err_fmt_d = 1'b1;  // number without '-' in range section
            end
          end
          S_HIGH: begin
            w_state_d = S_LOW;
            if (!w_has_digit) begin
              w_err_fmt_d = 1'b1;
            end else if (r_low > w_value) begin
`ifdef RANGE_ORDER_FIX_EN
              w_range_pend_d = 1'b1;
              w_rng_low_d    = w_value;
              w_rng_high_d   = r_low;
`else
              w_err_fmt_d = 1'b1;
`endif
            end else begin
              w_range_pend_d = 1'b1;
              w_rng_low_d    = r_low;
              w_rng_high_d   = w_value;
            end
          end
          S_ID: begin
            if (w_has_digit) begin
              w_id_valid_d = 1'b1;
              w_id_d       = w_value;
            end
          end
          default: w_state_d = S_LOW;
        endcase
      end else begin
        w_err_fmt_d = 1'b1;
        w_bad_d     = 1'b1;
        w_acc_clr   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_LOW;
      r_bad         <= 1'b0;
      r_low         <= '0;
      r_range_pend  <= 1'b0;
      r_rng_low     <= '0;
      r_rng_high    <= '0;
      r_id_valid    <= 1'b0;
      r_id          <= '0;
      r_done        <= 1'b0;
      r_err_fmt     <= 1'b0;
      r_err_ovf     <= 1'b0;
      r_range_count <= '0;
      r_id_count    <= '0;
    end else begin
      r_state      <= w_state_d;
      r_bad        <= w_bad_d;
      r_low        <= w_low_d;
      r_range_pend <= w_range_pend_d;
      r_rng_low    <= w_rng_low_d;
      r_rng_high   <= w_rng_high_d;
      r_id_valid   <= w_id_valid_d;
      r_id         <= w_id_d;
      r_done       <= w_done_d;
      r_err_fmt    <= w_err_fmt_d;
      r_err_ovf    <= w_err_ovf_d;
      if (wr_en && (r_range_count != '1)) r_range_count <= r_range_count + 1'b1;
      if (w_id_hs && (r_id_count != '1))  r_id_count    <= r_id_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_range_stream_parser.sv
module tb_range_stream_parser;

  localparam int unsigned AW = 17;
  localparam int unsigned CW = 16;
  localparam int ByteTimeout = 2000;

  logic          clk;
  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          fifo_ready;
  logic          wr_en;
  logic [AW-1:0] range_low;
  logic [AW-1:0] range_high;
  logic          range_fresh;
  logic          id_valid;
  logic          id_ready;
  logic [AW-1:0] id_addr;
  logic          ranges_done;
  logic          err_format;
  logic          err_overflow;
  logic [CW-1:0] range_count;
  logic [CW-1:0] id_count;

  int checks;
  int errors;
  int viol;
  logic rand_bp;

  logic [2*AW:0] wr_q[$];
  logic [AW-1:0] id_q[$];

  range_stream_parser #(
    .ADDR_W (AW),
    .CNT_W  (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .fifo_ready   (fifo_ready),
    .wr_en        (wr_en),
    .range_low    (range_low),
    .range_high   (range_high),
    .range_fresh  (range_fresh),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_addr      (id_addr),
    .ranges_done  (ranges_done),
    .err_format   (err_format),
    .err_overflow (err_overflow),
    .range_count  (range_count),
    .id_count     (id_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe transfers mid-cycle; inputs only change just after posedge.
  always @(negedge clk) begin
    if (wr_en) wr_q.push_back({range_low, range_high, range_fresh});
    if (id_valid && id_ready) id_q.push_back(id_addr);
    if (wr_en && !fifo_ready) viol++;
  end

  task automatic rand_ready();
    fifo_ready = 1'($urandom_range(0, 1));
    id_ready   = 1'($urandom_range(0, 1));
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (rand_bp) rand_ready();
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    fifo_ready = 1'b1;
    id_ready   = 1'b1;
    rand_bp    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < ByteTimeout) begin
      @(posedge clk);
      #1;
      if (rand_bp) rand_ready();
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: byte %h in_ready=%0b after %0d cycles, want 1", b, in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (rand_bp) rand_ready();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_num(input int unsigned v);
    logic [7:0] dig[$];
    int unsigned x;
    x = v;
    do begin
      dig.push_front(8'h30 + 8'(x % 10));
      x = x / 10;
    end while (x != 0);
    foreach (dig[i]) send_byte(dig[i]);
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    fifo_ready = 1'b1;
    id_ready   = 1'b1;
    rand_bp    = 1'b0;
    #3;
    checks++;
    if ({wr_en, id_valid, range_fresh, ranges_done, err_format, err_overflow} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {wr_en, id_valid, range_fresh, ranges_done, err_format, err_overflow});
    end
    checks++;
    if ({range_low, range_high, id_addr, range_count, id_count} !== '0) begin
      errors++;
      $display("FAIL reset_values: low=%0d high=%0d id=%0d rc=%0d ic=%0d want all 0",
               range_low, range_high, id_addr, range_count, id_count);
    end
    do_reset();
  endtask

  task automatic test_basic_ranges();
    int base;
    do_reset();
    base = wr_q.size();
    send_str("3-5\n10-14\n\n");
    tick(4);
    checks++;
    if (wr_q.size() - base != 2) begin
      errors++;
      $display("FAIL basic_nwrites: got %0d want 2", wr_q.size() - base);
    end else begin
      checks++;
      if (wr_q[base] !== {17'd3, 17'd5, 1'b1}) begin
        errors++;
        $display("FAIL basic_w0: got %h want %h", wr_q[base], {17'd3, 17'd5, 1'b1});
      end
      checks++;
      if (wr_q[base+1] !== {17'd10, 17'd14, 1'b1}) begin
        errors++;
        $display("FAIL basic_w1: got %h want %h", wr_q[base+1], {17'd10, 17'd14, 1'b1});
      end
    end
    checks++;
    if (ranges_done !== 1'b1 || range_count !== 16'd2 || err_format !== 1'b0) begin
      errors++;
      $display("FAIL basic_status: done=%0b rc=%0d efmt=%0b want 1 2 0",
               ranges_done, range_count, err_format);
    end
  endtask

  task automatic test_backpressure();
    int base;
    int bad;
    do_reset();
    base = wr_q.size();
    fifo_ready = 1'b0;
    send_str("3-5\n");
    in_data  = "1";
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || in_ready !== 1'b0) bad++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (bad != 0 || wr_q.size() != base) begin
      errors++;
      $display("FAIL bp_stall: bad_cycles=%0d writes=%0d want 0 0", bad, wr_q.size() - base);
    end
    fifo_ready = 1'b1;
    send_str("10-14\n\n");
    tick(4);
    checks++;
    if (wr_q.size() - base != 2 || wr_q[base] !== {17'd3, 17'd5, 1'b1}) begin
      errors++;
      $display("FAIL bp_writes: n=%0d first=%h want 2 %h", wr_q.size() - base,
               (wr_q.size() > base) ? wr_q[base] : '0, {17'd3, 17'd5, 1'b1});
    end
    checks++;
    if (range_count !== 16'd2 || viol != 0) begin
      errors++;
      $display("FAIL bp_count: rc=%0d viol=%0d want 2 0", range_count, viol);
    end
  endtask

  task automatic test_ids();
    int base;
    int bad;
    do_reset();
    base = id_q.size();
    id_ready = 1'b0;
    send_str("\n1\n");
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (id_valid !== 1'b1 || id_addr !== 17'd1 || in_ready !== 1'b0) bad++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL id_hold1: bad_cycles=%0d want 0", bad);
    end
    id_ready = 1'b1;
    send_str("5\n");
    id_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (id_valid !== 1'b1 || id_addr !== 17'd5) bad++;
      @(posedge clk);
      #1;
    end
    id_ready = 1'b1;
    tick(3);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL id_hold5: bad_cycles=%0d want 0", bad);
    end
    checks++;
    if (id_q.size() - base != 2 || id_q[base] !== 17'd1 || id_q[base+1] !== 17'd5) begin
      errors++;
      $display("FAIL id_seq: n=%0d want 2 ids {1,5}", id_q.size() - base);
    end
    checks++;
    if (id_count !== 16'd2 || ranges_done !== 1'b1 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL id_status: ic=%0d done=%0b vld=%0b want 2 1 0", id_count, ranges_done, id_valid);
    end
  endtask

  task automatic test_overflow();
    int base;
    do_reset();
    base = wr_q.size();
    send_str("131072-2\n");
    tick(3);
    checks++;
    if (err_overflow !== 1'b1 || wr_q.size() != base) begin
      errors++;
      $display("FAIL ovf_flag: eovf=%0b writes=%0d want 1 0", err_overflow, wr_q.size() - base);
    end
    send_str("4-6\n131071-131071\n");
    tick(3);
    checks++;
    if (wr_q.size() - base != 2 || wr_q[base] !== {17'd4, 17'd6, 1'b1}
        || wr_q[base+1] !== {17'd131071, 17'd131071, 1'b1}) begin
      errors++;
      $display("FAIL ovf_recover: n=%0d want 2 writes {4,6},{131071,131071}", wr_q.size() - base);
    end
    checks++;
    if (err_format !== 1'b0 || range_count !== 16'd2) begin
      errors++;
      $display("FAIL ovf_status: efmt=%0b rc=%0d want 0 2", err_format, range_count);
    end
  endtask

  task automatic test_order_and_format();
    int base;
    do_reset();
    base = wr_q.size();
    send_str("9-2\n");
    tick(3);
`ifdef RANGE_ORDER_FIX_EN
    checks++;
    if (wr_q.size() - base != 1 || wr_q[base] !== {17'd2, 17'd9, 1'b1} || err_format !== 1'b0) begin
      errors++;
      $display("FAIL order_swap: n=%0d efmt=%0b want 1 write {2,9} efmt 0",
               wr_q.size() - base, err_format);
    end
`else
    checks++;
    if (wr_q.size() != base || err_format !== 1'b1) begin
      errors++;
      $display("FAIL order_drop: writes=%0d efmt=%0b want 0 1", wr_q.size() - base, err_format);
    end
`endif
    do_reset();
    base = wr_q.size();
    send_str("1x-3\n-4\n7-8\r\n");
    tick(3);
    checks++;
    if (err_format !== 1'b1 || wr_q.size() - base != 1 || wr_q[base] !== {17'd7, 17'd8, 1'b1}) begin
      errors++;
      $display("FAIL bad_line: efmt=%0b n=%0d want 1 and one write {7,8}", err_format,
               wr_q.size() - base);
    end
  endtask

  task automatic test_reset_pending();
    int base;
    do_reset();
    base = wr_q.size();
    fifo_ready = 1'b0;
    send_str("7-8\n");
    tick(2);
    rst_n = 1'b0;
    fifo_ready = 1'b1;
    #1;
    checks++;
    if (wr_en !== 1'b0 || range_fresh !== 1'b0) begin
      errors++;
      $display("FAIL rstpend_immediate: wr_en=%0b fresh=%0b want 0 0", wr_en, range_fresh);
    end
    tick(2);
    rst_n = 1'b1;
    tick(3);
    checks++;
    if (wr_q.size() != base || range_count !== '0 || {range_low, range_high} !== '0) begin
      errors++;
      $display("FAIL rstpend_after: writes=%0d rc=%0d low=%0d high=%0d want all 0",
               wr_q.size() - base, range_count, range_low, range_high);
    end
    send_str("1-2\n");
    tick(3);
    checks++;
    if (wr_q.size() - base != 1 || wr_q[base] !== {17'd1, 17'd2, 1'b1}) begin
      errors++;
      $display("FAIL rstpend_restart: n=%0d want one write {1,2}", wr_q.size() - base);
    end
  endtask

  task automatic test_random();
    logic [2*AW:0] exp_w[$];
    logic [AW-1:0] exp_id[$];
    logic          exp_efmt;
    int unsigned   lo, hi, v;
    int base_w, base_i;
    int bad;
    do_reset();
    base_w = wr_q.size();
    base_i = id_q.size();
    exp_efmt = 1'b0;
    rand_bp = 1'b1;
    for (int r = 0; r < 14; r++) begin
      lo = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 131071);
      hi = ($urandom_range(0, 3) == 0) ? lo + $urandom_range(0, 5) : $urandom_range(0, 131071);
      if (hi > 131071) hi = 131071;
      if (lo <= hi) exp_w.push_back({AW'(lo), AW'(hi), 1'b1});
`ifdef RANGE_ORDER_FIX_EN
      else exp_w.push_back({AW'(hi), AW'(lo), 1'b1});
`else
      else exp_efmt = 1'b1;
`endif
      send_num(lo);
      send_byte("-");
      send_num(hi);
      if ($urandom_range(0, 2) == 0) send_byte(8'h0d);
      send_byte(8'h0a);
    end
    send_byte(8'h0a);
    for (int k = 0; k < 12; k++) begin
      v = $urandom_range(0, 131071);
      exp_id.push_back(AW'(v));
      send_num(v);
      send_byte(8'h0a);
      if ($urandom_range(0, 3) == 0) send_byte(8'h0a);
    end
    rand_bp = 1'b0;
    fifo_ready = 1'b1;
    id_ready = 1'b1;
    tick(5);
    checks++;
    if (wr_q.size() - base_w != exp_w.size()) begin
      errors++;
      $display("FAIL rand_nwrites: got %0d want %0d", wr_q.size() - base_w, exp_w.size());
    end else begin
      bad = 0;
      foreach (exp_w[i]) if (wr_q[base_w+i] !== exp_w[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rand_writes: %0d entries differ from expected", bad);
      end
    end
    checks++;
    if (id_q.size() - base_i != exp_id.size()) begin
      errors++;
      $display("FAIL rand_nids: got %0d want %0d", id_q.size() - base_i, exp_id.size());
    end else begin
      bad = 0;
      foreach (exp_id[i]) if (id_q[base_i+i] !== exp_id[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rand_ids: %0d entries differ from expected", bad);
      end
    end
    checks++;
    if (range_count !== CW'(exp_w.size()) || id_count !== CW'(exp_id.size())
        || err_format !== exp_efmt || err_overflow !== 1'b0 || ranges_done !== 1'b1) begin
      errors++;
      $display("FAIL rand_status: rc=%0d ic=%0d efmt=%0b eovf=%0b done=%0b want %0d %0d %0b 0 1",
               range_count, id_count, err_format, err_overflow, ranges_done,
               exp_w.size(), exp_id.size(), exp_efmt);
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL full_write: wr_en with fifo_ready=0 seen %0d times, want 0", viol);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    viol   = 0;
    test_reset();
    test_basic_ranges();
    test_backpressure();
    test_ids();
    test_overflow();
    test_order_and_format();
    test_reset_pending();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
